and_or_arbiter: RTL and testbench

//   Shares one combinational AND-OR evaluation unit, out = in3 | (in1 & in2), between
//   NUM_REQ requesters. Round-robin grant; each operand is captured into a register,

---
 rtl/and_or_arb_pkg.sv | 31 +++
 rtl/and_or_eval.sv | 11 +
 rtl/and_or_arbiter.sv | 107 ++++++++++
 tb/tb_and_or_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/and_or_arb_pkg.sv
// Shared types and the round-robin pick helper for the AND-OR arbiter.
package and_or_arb_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam int OPERAND_W = 3;
  localparam int MAX_REQ   = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit scanning ptr+1, ptr+2, ... modulo n; ptr itself is visited last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [3:0]         ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      j = (32'(ptr) + k) % n;
      if (k <= n && !p.found && req[j[3:0]]) begin
        p.found = 1'b1;
        p.idx   = j[3:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/and_or_eval.sv
// Shared combinational evaluation unit: out = in3 | (in1 & in2), operand = {in3,in2,in1}.
module and_or_eval
  import and_or_arb_pkg::*;
(
  input  logic [OPERAND_W-1:0] i_operand,
  output logic                 o_result
);

  assign o_result = i_operand[2] | (i_operand[0] & i_operand[1]);

endmodule

// File: rtl/and_or_arbiter.sv
// Round-robin arbiter sharing one AND-OR evaluator between NUM_REQ requesters.
// Optional per-requester grant counters when ANDOR_ARB_STATS_EN is defined.
module and_or_arbiter
  import and_or_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int STAT_W  = 16,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [OPERAND_W*NUM_REQ-1:0]   req_operand,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic                           rsp_data,
  output logic                           busy
`ifdef ANDOR_ARB_STATS_EN
  ,
  input  logic                           stat_clear,
  output logic [NUM_REQ*STAT_W-1:0]      grant_cnt
`endif
);

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, r_id, w_win;
  logic [OPERAND_W-1:0]  r_opnd, w_opnd_sel;
  logic                  r_result, w_eval_res, w_hs;
  logic [MAX_REQ-1:0]    w_req_pad;
  pick_t                 w_pick;
  logic                  w_unused_idx;

  assign w_req_pad    = MAX_REQ'(req_valid);
  assign w_pick       = rr_pick(w_req_pad, 4'(r_rr_ptr), NUM_REQ);
  assign w_win        = ID_W'(w_pick.idx);
  assign w_unused_idx = ^w_pick.idx;
  assign w_opnd_sel   = req_operand[OPERAND_W*w_win +: OPERAND_W];
  assign w_hs         = |(req_valid & req_ready);

  and_or_eval u_eval (
    .i_operand (r_opnd),
    .o_result  (w_eval_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // req_ready is gated by rst_n so every output reads zero while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: if (w_pick.found && rst_n) begin
        req_ready[w_win] = 1'b1;
        w_state_nxt      = EVAL;
      end
      EVAL: w_state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
      r_id     <= '0;
      r_opnd   <= '0;
      r_result <= 1'b0;
    end else begin
      if (w_hs) begin
        r_opnd   <= w_opnd_sel;
        r_id     <= w_win;
        r_rr_ptr <= w_win;
      end
      if (r_state == EVAL) r_result <= w_eval_res;
    end
  end

  assign rsp_id   = r_id;
  assign rsp_data = r_result;

`ifdef ANDOR_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [STAT_W-1:0] r_cnt;
    // Clear has priority over a coincident grant.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                           r_cnt <= '0;
      else if (stat_clear)                                  r_cnt <= '0;
      else if (req_valid[g] && req_ready[g] && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
    assign grant_cnt[STAT_W*g +: STAT_W] = r_cnt;
  end
`else
  logic [STAT_W-1:0] w_unused_stat;
  assign w_unused_stat = '0;
`endif

endmodule

// File: tb/tb_and_or_arbiter.sv
// Directed bench for and_or_arbiter: a 4-requester instance and a 1-requester instance.
module tb_and_or_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [11:0] req_operand;
  logic        rsp_valid, rsp_ready, rsp_data, busy;
  logic [1:0]  rsp_id;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_data1, busy1;
  logic [2:0]  req_operand1;
  logic [0:0]  rsp_id1;
`ifdef ANDOR_ARB_STATS_EN
  logic        stat_clear;
  logic [7:0]  grant_cnt;
  logic [1:0]  grant_cnt1;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  and_or_arbiter #(.NUM_REQ(4), .STAT_W(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand (req_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef ANDOR_ARB_STATS_EN
    ,
    .stat_clear  (stat_clear),
    .grant_cnt   (grant_cnt)
`endif
  );

  and_or_arbiter #(.NUM_REQ(1), .STAT_W(2)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid1),
    .req_ready   (req_ready1),
    .req_operand (req_operand1),
    .rsp_valid   (rsp_valid1),
    .rsp_ready   (rsp_ready1),
    .rsp_id      (rsp_id1),
    .rsp_data    (rsp_data1),
    .busy        (busy1)
`ifdef ANDOR_ARB_STATS_EN
    ,
    .stat_clear  (1'b0),
    .grant_cnt   (grant_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_operand = '0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_operand1 = '0; rsp_ready1 = 1'b0;
`ifdef ANDOR_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int         ord [5] = '{0, 1, 2, 3, 0};
  logic       exp_d [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] tbl;

  initial begin
    tbl = 8'b1111_1000;
    rst_n = 1'b0;
    req_valid = '0; req_operand = '0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_operand1 = '0; rsp_ready1 = 1'b0;
`ifdef ANDOR_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, operand 011 -> 1
    @(negedge clk);
    req_valid = 4'b0001; req_operand = 12'h003; rsp_ready = 1'b1;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1 chk("t1_eval_valid", 32'(rsp_valid), 0);
    chk("t1_eval_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_data", 32'(rsp_data), 1);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 0);

    // all four requesting: order 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111;
    req_operand = {3'b011, 3'b010, 3'b100, 3'b000};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_ready", 32'(req_ready), 32'(1 << ord[i]));
      @(negedge clk);
      chk("t2_eval_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("t2_rsp_valid", 32'(rsp_valid), 1);
      chk("t2_rsp_id", 32'(rsp_id), 32'(ord[i]));
      chk("t2_rsp_data", 32'(rsp_data), 32'(exp_d[i]));
      @(negedge clk);
    end

    // backpressure: requester 1 wins, response held for 5 cycles
    rsp_ready = 1'b0;
    #1 chk("t3_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    @(negedge clk);
    repeat (5) begin
      #1;
      chk("t3_hold_valid", 32'(rsp_valid), 1);
      chk("t3_hold_id", 32'(rsp_id), 1);
      chk("t3_hold_data", 32'(rsp_data), 1);
      chk("t3_hold_ready", 32'(req_ready), 0);
      chk("t3_hold_busy", 32'(busy), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("t3_next_ready", 32'(req_ready), 32'h4);
    req_valid = '0;
    @(negedge clk);
    chk("t3_drop_busy", 32'(busy), 0);

    // reset during EVAL
    do_reset();
    req_valid = 4'b0010; req_operand = {3'b000, 3'b000, 3'b111, 3'b000}; rsp_ready = 1'b1;
    #1 chk("t4_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    chk("t4_eval_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_valid", 32'(rsp_valid), 0);
    chk("t4_rst_ready", 32'(req_ready), 0);
    chk("t4_rst_id", 32'(rsp_id), 0);
    chk("t4_rst_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t4_first_win", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);

`ifdef ANDOR_ARB_STATS_EN
    // counters: 5 grants to requester 1 saturate a 2-bit counter
    do_reset();
    req_valid = 4'b0010; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(negedge clk);
      if (i == 1) chk("t5_cnt_two", 32'(grant_cnt[3:2]), 2);
    end
    #1 chk("t5_cnt_sat", 32'(grant_cnt[3:2]), 3);
    chk("t5_cnt_other", 32'(grant_cnt[1:0]), 0);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    #1 chk("t5_clear_win", 32'(grant_cnt[3:2]), 0);
    chk("t5_clear_busy", 32'(busy), 1);
    req_valid = '0;
    repeat (3) @(negedge clk);
`endif

    // single requester: exhaustive operands, back-to-back
    rsp_ready1 = 1'b1;
    req_valid1 = 1'b1;
    for (int v = 0; v < 8; v++) begin
      req_operand1 = 3'(v);
      #1 chk("t6_ready", 32'(req_ready1), 1);
      @(negedge clk);
      @(negedge clk);
      chk("t6_valid", 32'(rsp_valid1), 1);
      chk("t6_id", 32'(rsp_id1), 0);
      chk("t6_data", 32'(rsp_data1), 32'(tbl[v]));
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("t6_idle", 32'(busy1), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
